// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - display geometry defaults, colours, sprite codes and accumulator saturation
package vga_pkg;

  localparam int HD_DEF = 640;
  localparam int VD_DEF = 480;
  localparam int PW_DEF = 16;
  localparam int PH_DEF = 16;

  localparam logic [11:0] COL_BLACK = 12'h000;
  localparam logic [11:0] COL_WHITE = 12'hFFF;
  localparam logic [11:0] COL_RED   = 12'hF00;
  localparam logic [11:0] COL_GREEN = 12'h0F0;

  typedef enum logic [1:0] {
    SPR_CLEAR   = 2'd0,
    SPR_OUTLINE = 2'd1,
    SPR_FILL    = 2'd2,
    SPR_ACCENT  = 2'd3
  } sprite_code_e;

  function automatic logic signed [11:0] sat12(input logic signed [12:0] v);
    if (v > 13'sd2047)
      return 12'sh7FF;
    else if (v < -13'sd2048)
      return 12'sh800;
    else
      return v[11:0];
  endfunction

endpackage

// File: rtl/pointer_rom.sv
// rtl/pointer_rom.sv - 16x16x2 arrow bitmap, synchronous read at address {rel_y, rel_x}
module pointer_rom
  import vga_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   i_addr,
  output sprite_code_e o_code
);

  // Arrow: left edge and diagonal outlined, bottom row outlined, a 4x4 accent patch inside.
  function automatic logic [1:0] pixel_code(input int x, input int y);
    if (x > y)
      return SPR_CLEAR;
    else if (x >= 5 && x <= 8 && y >= 8 && y <= 11)
      return SPR_ACCENT;
    else if (x == 0 || x == y || y == 15)
      return SPR_OUTLINE;
    else
      return SPR_FILL;
  endfunction

  function automatic logic [511:0] build_rom();
    logic [511:0] bits;
    bits = '0;
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        bits[(y*16 + x)*2 +: 2] = pixel_code(x, y);
    return bits;
  endfunction

  localparam logic [511:0] ROM_BITS = build_rom();

  sprite_code_e r_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_code <= SPR_CLEAR;
    else
      r_code <= sprite_code_e'(ROM_BITS[{i_addr, 1'b0} +: 2]);
  end

  assign o_code = r_code;

endmodule

// File: rtl/mouse_pointer_overlay.sv
// rtl/mouse_pointer_overlay.sv - accumulates mouse deltas, moves the pointer once per frame,
// and composites the sprite over the background with a fixed 2-cycle render latency.
module mouse_pointer_overlay
  import vga_pkg::*;
#(
  parameter int HD = HD_DEF,
  parameter int VD = VD_DEF,
  parameter int PW = PW_DEF,
  parameter int PH = PH_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m_done_tick,
  input  logic [8:0]  m_xm,
  input  logic [8:0]  m_ym,
  input  logic [2:0]  m_btn,
  input  logic        video_on_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [11:0] pixel_x,
  input  logic [11:0] pixel_y,
  input  logic [11:0] bg_rgb,
  output logic [11:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [11:0] ptr_x,
  output logic [11:0] ptr_y
);

  localparam int X_MAX = HD - PW;
  localparam int Y_MAX = VD - PH;

  function automatic logic [11:0] clamp(input logic signed [12:0] v,
                                        input logic signed [12:0] hi);
    if (v < 13'sd0)
      return 12'd0;
    else if (v > hi)
      return hi[11:0];
    else
      return v[11:0];
  endfunction

  logic signed [11:0] r_acc_x, r_acc_y;
  logic [2:0]         r_btn_q;
  logic [11:0]        r_ptr_x, r_ptr_y;

  logic signed [12:0] w_dx13, w_dy13, w_sum_x, w_sum_y, w_nx, w_ny;
  logic               w_frame_tick;

  assign w_frame_tick = (pixel_x == 12'd0) && (pixel_y == 12'(VD));
  assign w_dx13  = {{4{m_xm[8]}}, m_xm};
  assign w_dy13  = {{4{m_ym[8]}}, m_ym};
  assign w_sum_x = {r_acc_x[11], r_acc_x} + w_dx13;
  assign w_sum_y = {r_acc_y[11], r_acc_y} - w_dy13;
  assign w_nx    = {1'b0, r_ptr_x} + {r_acc_x[11], r_acc_x};
  assign w_ny    = {1'b0, r_ptr_y} + {r_acc_y[11], r_acc_y};

  // A packet landing on the frame tick seeds the fresh accumulators; the move uses the old ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_x <= 12'sd0;
      r_acc_y <= 12'sd0;
      r_btn_q <= 3'b000;
      r_ptr_x <= 12'(X_MAX / 2);
      r_ptr_y <= 12'(Y_MAX / 2);
    end else begin
      if (m_done_tick)
        r_btn_q <= m_btn;
      if (w_frame_tick) begin
        r_ptr_x <= clamp(w_nx, 13'(X_MAX));
        r_ptr_y <= clamp(w_ny, 13'(Y_MAX));
        r_acc_x <= m_done_tick ? sat12(w_dx13) : 12'sd0;
        r_acc_y <= m_done_tick ? sat12(-w_dy13) : 12'sd0;
      end else if (m_done_tick) begin
        r_acc_x <= sat12(w_sum_x);
        r_acc_y <= sat12(w_sum_y);
      end
    end
  end

  logic [11:0]  w_off_x, w_off_y;
  logic         w_hit;
  sprite_code_e w_code;

  assign w_off_x = pixel_x - r_ptr_x;
  assign w_off_y = pixel_y - r_ptr_y;
  assign w_hit   = video_on_in && (w_off_x < 12'(PW)) && (w_off_y < 12'(PH));

  // The ROM output register doubles as the S1 register for the sprite address.
  pointer_rom u_rom (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_addr ({w_off_y[3:0], w_off_x[3:0]}),
    .o_code (w_code)
  );

  logic        r_hit, r_von1, r_von2, r_hs1, r_hs2, r_vs1, r_vs2;
  logic [11:0] r_bg, r_rgb;
  logic [11:0] w_sprite_rgb, w_rgb_next;

  always_comb begin
    w_sprite_rgb = r_bg;
    case (w_code)
      SPR_OUTLINE: w_sprite_rgb = COL_BLACK;
      SPR_FILL:    w_sprite_rgb = COL_WHITE;
      SPR_ACCENT:  w_sprite_rgb = r_btn_q[0] ? COL_RED :
                                  (r_btn_q[1] ? COL_GREEN : COL_WHITE);
      default:     w_sprite_rgb = r_bg;
    endcase
    w_rgb_next = COL_BLACK;
    if (r_von1)
      w_rgb_next = r_hit ? w_sprite_rgb : r_bg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit  <= 1'b0;
      r_bg   <= 12'h000;
      r_von1 <= 1'b0;
      r_von2 <= 1'b0;
      r_hs1  <= 1'b1;
      r_hs2  <= 1'b1;
      r_vs1  <= 1'b1;
      r_vs2  <= 1'b1;
      r_rgb  <= 12'h000;
    end else begin
      r_hit  <= w_hit;
      r_bg   <= bg_rgb;
      r_von1 <= video_on_in;
      r_von2 <= r_von1;
      r_hs1  <= hsync_in;
      r_hs2  <= r_hs1;
      r_vs1  <= vsync_in;
      r_vs2  <= r_vs1;
      r_rgb  <= w_rgb_next;
    end
  end

  logic w_unused_btn;
  assign w_unused_btn = r_btn_q[2];

  assign rgb      = r_rgb;
  assign hsync    = r_hs2;
  assign vsync    = r_vs2;
  assign video_on = r_von2;
  assign ptr_x    = r_ptr_x;
  assign ptr_y    = r_ptr_y;

endmodule
